issue_scheduler: RTL and testbench
==================================

Name: issue_scheduler

Overview:
- Wakeup/issue stage controller for the 16-entry instruction buffer.
- Each cycle it scans the buffer entry summaries and selects up to two ready operations, oldest first (lowest index = oldest).
- It enforces per-cycle execution-unit structural limits and tracks the iterative divider's busy time.
- It drives registered issue slots (tag + mode) to the EX stage and the buffer's EXECUTING transition.

Parameters:
- BUF_SIZE, 16, number of buffer entries; tag width is log2(BUF_SIZE) = 4.
- DIV_LATENCY, 32, cycles the divider stays busy after a DIV issue.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- ent_wait  in  BUF_SIZE  bit i: entry i state is S_NOT_EXECUTED.
- ent_addr_gen  in  BUF_SIZE  bit i: entry i state is S_ADDR_GENERATED.
- ent_j_rdy  in  BUF_SIZE  operand J ready per entry.
- ent_k_rdy  in  BUF_SIZE  operand K ready per entry.
- ent_unit  in  3*BUF_SIZE  unit_t per entry; entry i occupies bits [3i+2:3i].
- ent_early_st  in  4*BUF_SIZE  number_of_early_store_ops per entry.
- ent_tag  in  4*BUF_SIZE  tag per entry.
- flush  in  1  branch misprediction established this cycle.
- ex_stall  in  1  EX cannot accept; hold issue slots.
- issue_valid  out  2  slot valid.
- issue_tag  out  2x4  issued tag per slot.
- issue_mode  out  2  ex_mode_t per slot (0 = EX_NORMAL, 1 = EX_GEN_ADDR).
- div_busy  out  1  divider occupied.

Behaviour:
- Reset (reset=0 at a clk edge): issue_valid=0, issue_tag=0, issue_mode=0, div_busy=0, div counter=0, inflight mask=0.
- Candidate rules, all combinational on the current inputs:
  - ALU, BRANCH, MUL, DIV: ent_wait & J_rdy & K_rdy, mode EX_NORMAL.
  - LOAD address generation: ent_wait & J_rdy, mode EX_GEN_ADDR.
  - STORE address generation: ent_wait & J_rdy & K_rdy, mode EX_GEN_ADDR.
  - LOAD memory access: ent_addr_gen & ent_early_st==0, mode EX_NORMAL.
  - Any entry whose tag is in the inflight mask is excluded.
- Selection:
  - Slot0 takes the lowest-index candidate.
  - Slot1 takes the next lowest-index candidate that is compatible with slot0.
  - Per cycle the two slots carry at most one DIV, one BRANCH and one memory-access LOAD. MUL and address generations are unlimited.
  - DIV is not a candidate while div_busy=1.
  - If slot0 is empty, slot1 is empty.
- Latency: selection is registered, so entries sampled in cycle N appear on issue_* in cycle N+1.
- Inflight mask:
  - Set to the issued tags when registering. It suppresses re-selection during the one cycle before the buffer shows S_EXECUTING.
  - Cleared on every non-stalled cycle.
- ex_stall=1: issue_* and the inflight mask hold their values; no new selection is made. The div counter still decrements.
- Divider:
  - An issued DIV (registered on issue, not stalled) loads the counter with DIV_LATENCY and sets div_busy=1 in the same edge.
  - The counter decrements each cycle. div_busy falls on the edge where the count reaches 0.
  - A DIV can issue in the cycle after div_busy falls.
- flush=1: on the next edge issue_valid=0 and the inflight mask is cleared, overriding stall and selection.
  - The div counter is not affected: the squashed divide still occupies the unit, and its result is dropped by tag mismatch.
- Simultaneous flush and reset: reset wins.
- Reset asserted mid-divide: the counter clears immediately.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles with random inputs -> all outputs 0. Release with no candidates -> issue_valid=00 indefinitely.
- Oldest-first dual issue: ALU-ready entries at indexes 3, 7 and 9 (tags 3, 7, 9) -> next cycle issue_valid=11, tag0=3, tag1=7, mode=00. With inputs unchanged, the following cycle issues tag 9 only, because 3 and 7 are masked as inflight.
- DIV structural: DIV-ready entries at 1 and 2 -> only tag1 issues and div_busy=1 for 32 cycles. Tag 2 issues exactly 33 cycles after tag 1.
- Load ordering: LOAD at index 5 in S_ADDR_GENERATED with ent_early_st=2 -> not issued. Set to 0 -> issued next cycle with mode EX_NORMAL. A second memory-access LOAD at index 6 in the same cycle waits one more cycle.
- Stall and flush: tags 4 and 8 are issued and ex_stall=1 for 3 cycles -> outputs held at 4/8. Assert flush with the stall still active -> issue_valid=00 on the next edge.
- Branch limit: BRANCH-ready entries at 0 and 1 plus an ALU at 2 -> slot0=0 and slot1=2. Tag 1 issues the next cycle.

Source files
------------

// File: rtl/issue_scheduler.sv
// issue_scheduler -- wakeup/issue stage controller for the instruction buffer.
//
// Scans the per-entry summaries every cycle and registers up to two ready
// operations (oldest = lowest index first) into the EX issue slots, honouring
// per-cycle unit limits (one DIV, one BRANCH, one memory-access LOAD) and the
// iterative divider's busy window.
//
// unit_t encoding (3 bits per entry):
//   0 ALU, 1 BRANCH, 2 MUL, 3 DIV, 4 LOAD, 5 STORE (6/7 never issue)
// ex_mode_t: 0 EX_NORMAL, 1 EX_GEN_ADDR
//
// Ports:
//   clk, reset         clock, synchronous active-low reset
//   ent_wait           entry is S_NOT_EXECUTED
//   ent_addr_gen       entry is S_ADDR_GENERATED
//   ent_j_rdy/k_rdy    operand readiness
//   ent_unit           unit_t per entry, entry i at [3i+2:3i]
//   ent_early_st       older stores still pending per entry
//   ent_tag            tag per entry
//   flush              squash slots and inflight mask on the next edge
//   ex_stall           hold slots and inflight mask
//   issue_valid/tag/mode  registered issue slots (index 0 = slot0)
//   div_busy           divider occupied

module issue_cand (
  input  logic       wait_st,
  input  logic       addr_gen,
  input  logic       j_rdy,
  input  logic       k_rdy,
  input  logic [2:0] unit,
  input  logic [3:0] early_st,
  input  logic       masked,
  input  logic       div_busy,
  output logic       cand,
  output logic       mode,
  output logic       is_div,
  output logic       is_br,
  output logic       is_mld
);
  localparam logic [2:0] U_ALU = 3'd0, U_BR = 3'd1, U_MUL = 3'd2,
                         U_DIV = 3'd3, U_LD = 3'd4, U_ST = 3'd5;

  logic ops_rdy, raw;

  assign ops_rdy = wait_st & j_rdy & k_rdy;

  always_comb begin
    raw    = 1'b0;
    mode   = 1'b0;
    is_div = 1'b0;
    is_br  = 1'b0;
    is_mld = 1'b0;
    case (unit)
      U_ALU, U_MUL: raw = ops_rdy;
      U_BR: begin
        raw   = ops_rdy;
        is_br = 1'b1;
      end
      U_DIV: begin
        raw    = ops_rdy & ~div_busy;
        is_div = 1'b1;
      end
      U_LD: begin
        // Address generation only needs the base operand; the memory
        // access waits until every older store has resolved.
        if (wait_st && j_rdy) begin
          raw  = 1'b1;
          mode = 1'b1;
        end else if (addr_gen && early_st == 4'd0) begin
          raw    = 1'b1;
          is_mld = 1'b1;
        end
      end
      U_ST: begin
        raw  = ops_rdy;
        mode = 1'b1;
      end
      default: raw = 1'b0;
    endcase
    cand = raw & ~masked;
  end
endmodule

module issue_scheduler #(
  parameter int BUF_SIZE    = 16,
  parameter int DIV_LATENCY = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BUF_SIZE-1:0]               ent_wait,
  input  logic [BUF_SIZE-1:0]               ent_addr_gen,
  input  logic [BUF_SIZE-1:0]               ent_j_rdy,
  input  logic [BUF_SIZE-1:0]               ent_k_rdy,
  input  logic [3*BUF_SIZE-1:0]             ent_unit,
  input  logic [4*BUF_SIZE-1:0]             ent_early_st,
  input  logic [$clog2(BUF_SIZE)*BUF_SIZE-1:0] ent_tag,
  input  logic                              flush,
  input  logic                              ex_stall,
  output logic [1:0]                        issue_valid,
  output logic [1:0][$clog2(BUF_SIZE)-1:0]  issue_tag,
  output logic [1:0]                        issue_mode,
  output logic                              div_busy
);
  localparam int TAG_W = $clog2(BUF_SIZE);
  localparam int CNT_W = $clog2(DIV_LATENCY + 1);

  logic [BUF_SIZE-1:0] inflight;
  logic [CNT_W-1:0]    div_cnt;

  logic [BUF_SIZE-1:0] cand, mode, is_div, is_br, is_mld;

  // Per-entry candidate decode
  for (genvar i = 0; i < BUF_SIZE; i++) begin : g_ent
    logic [TAG_W-1:0] tag_i;
    assign tag_i = ent_tag[TAG_W*i +: TAG_W];
    issue_cand u_cand (
      .wait_st  (ent_wait[i]),
      .addr_gen (ent_addr_gen[i]),
      .j_rdy    (ent_j_rdy[i]),
      .k_rdy    (ent_k_rdy[i]),
      .unit     (ent_unit[3*i +: 3]),
      .early_st (ent_early_st[4*i +: 4]),
      .masked   (inflight[tag_i]),
      .div_busy (div_busy),
      .cand     (cand[i]),
      .mode     (mode[i]),
      .is_div   (is_div[i]),
      .is_br    (is_br[i]),
      .is_mld   (is_mld[i])
    );
  end

  // Two-slot oldest-first pick. Slot1 skips anything that would double up
  // a singly-provisioned unit with slot0.
  logic             s0_vld, s1_vld;
  logic [TAG_W-1:0] s0_idx, s1_idx;
  logic             s0_div, s0_br, s0_mld;

  always_comb begin
    s0_vld = 1'b0;
    s0_idx = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (!s0_vld && cand[i]) begin
        s0_vld = 1'b1;
        s0_idx = TAG_W'(i);
      end
    end
    s0_div = is_div[s0_idx];
    s0_br  = is_br[s0_idx];
    s0_mld = is_mld[s0_idx];

    s1_vld = 1'b0;
    s1_idx = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (s0_vld && !s1_vld && cand[i] && TAG_W'(i) > s0_idx &&
          !(is_div[i] && s0_div) && !(is_br[i] && s0_br) &&
          !(is_mld[i] && s0_mld)) begin
        s1_vld = 1'b1;
        s1_idx = TAG_W'(i);
      end
    end
  end

  logic [1:0][TAG_W-1:0] sel_tag;
  logic [BUF_SIZE-1:0]   sel_mask;
  logic                  sel_div, adv;

  assign sel_tag[0] = ent_tag[TAG_W*s0_idx +: TAG_W];
  assign sel_tag[1] = ent_tag[TAG_W*s1_idx +: TAG_W];

  always_comb begin
    sel_mask = '0;
    if (s0_vld) sel_mask[sel_tag[0]] = 1'b1;
    if (s1_vld) sel_mask[sel_tag[1]] = 1'b1;
  end

  // A selection only takes effect on an edge that neither flushes nor stalls.
  assign adv     = !flush && !ex_stall;
  assign sel_div = (s0_vld && s0_div) || (s1_vld && is_div[s1_idx]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_valid <= '0;
      issue_tag   <= '0;
      issue_mode  <= '0;
      inflight    <= '0;
      div_cnt     <= '0;
      div_busy    <= 1'b0;
    end else begin
      // Divider keeps counting through stalls and flushes: a squashed
      // divide still owns the unit until it finishes.
      if (adv && sel_div) begin
        div_cnt  <= CNT_W'(DIV_LATENCY);
        div_busy <= 1'b1;
      end else if (div_cnt != '0) begin
        div_cnt  <= div_cnt - 1'b1;
        div_busy <= (div_cnt != CNT_W'(1));
      end

      if (flush) begin
        issue_valid <= '0;
        inflight    <= '0;
      end else if (!ex_stall) begin
        issue_valid <= {s1_vld, s0_vld};
        issue_tag   <= sel_tag;
        issue_mode  <= {s1_vld & mode[s1_idx], s0_vld & mode[s0_idx]};
        // Covers the one cycle before the buffer reports S_EXECUTING.
        inflight    <= sel_mask;
      end
    end
  end
endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: each step pushes the hand-derived
// expected slot state, then pops and compares it after the clock edge.
module tb_issue_scheduler;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  ent_wait, ent_addr_gen, ent_j_rdy, ent_k_rdy;
  logic [3*N-1:0] ent_unit;
  logic [4*N-1:0] ent_early_st;
  logic [4*N-1:0] ent_tag;
  logic          flush, ex_stall;
  logic [1:0]    issue_valid;
  logic [1:0][3:0] issue_tag;
  logic [1:0]    issue_mode;
  logic          div_busy;

  issue_scheduler #(.BUF_SIZE(16), .DIV_LATENCY(32)) dut (
    .clk(clk), .reset(reset),
    .ent_wait(ent_wait), .ent_addr_gen(ent_addr_gen),
    .ent_j_rdy(ent_j_rdy), .ent_k_rdy(ent_k_rdy),
    .ent_unit(ent_unit), .ent_early_st(ent_early_st), .ent_tag(ent_tag),
    .flush(flush), .ex_stall(ex_stall),
    .issue_valid(issue_valid), .issue_tag(issue_tag),
    .issue_mode(issue_mode), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;
    logic [3:0] t0;
    logic [3:0] t1;
    logic [1:0] m;
    logic       b;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [2:0] ALU = 3'd0, BR = 3'd1, DIV = 3'd3, LD = 3'd4, ST = 3'd5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ent_wait = '0; ent_addr_gen = '0; ent_j_rdy = '0; ent_k_rdy = '0;
    ent_unit = '0; ent_early_st = '0; flush = 1'b0; ex_stall = 1'b0;
    for (int i = 0; i < N; i++) ent_tag[4*i +: 4] = 4'(i);
  endtask

  task automatic set_ent(input int idx, input logic [2:0] u, input logic w,
                         input logic ag, input logic j, input logic k,
                         input logic [3:0] est);
    ent_unit[3*idx +: 3]     = u;
    ent_wait[idx]            = w;
    ent_addr_gen[idx]        = ag;
    ent_j_rdy[idx]           = j;
    ent_k_rdy[idx]           = k;
    ent_early_st[4*idx +: 4] = est;
  endtask

  // Push expectation, clock, then pop and compare.
  task automatic step(input string nm, input logic [1:0] v, input logic [3:0] t0,
                      input logic [3:0] t1, input logic [1:0] m, input logic b);
    exp_t e;
    e.v = v; e.t0 = t0; e.t1 = t1; e.m = m; e.b = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({nm, ".valid"}, 32'(issue_valid), 32'(e.v));
    chk({nm, ".busy"}, 32'(div_busy), 32'(e.b));
    if (e.v[0]) begin
      chk({nm, ".tag0"}, 32'(issue_tag[0]), 32'(e.t0));
      chk({nm, ".mode0"}, 32'(issue_mode[0]), 32'(e.m[0]));
    end
    if (e.v[1]) begin
      chk({nm, ".tag1"}, 32'(issue_tag[1]), 32'(e.t1));
      chk({nm, ".mode1"}, 32'(issue_mode[1]), 32'(e.m[1]));
    end
  endtask

  initial begin
    clr();
    // Reset with random inputs
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      ent_wait = 16'($urandom); ent_addr_gen = 16'($urandom);
      ent_j_rdy = 16'($urandom); ent_k_rdy = 16'($urandom);
      ent_unit = 48'({$urandom, $urandom});
      ent_early_st = 64'({$urandom, $urandom});
      flush = 1'($urandom); ex_stall = 1'($urandom);
      step("rst", 2'b00, 0, 0, 2'b00, 1'b0);
    end
    chk("rst.tags", 32'(issue_tag), 32'h0);
    chk("rst.mode", 32'(issue_mode), 32'h0);
    reset = 1'b1;
    clr();
    for (int c = 0; c < 3; c++) step("idle", 2'b00, 0, 0, 2'b00, 1'b0);

    // Oldest-first dual issue, then inflight masking
    set_ent(3, ALU, 1, 0, 1, 1, 0);
    set_ent(7, ALU, 1, 0, 1, 1, 0);
    set_ent(9, ALU, 1, 0, 1, 1, 0);
    step("dual", 2'b11, 3, 7, 2'b00, 1'b0);
    step("mask", 2'b01, 9, 0, 2'b00, 1'b0);
    clr();
    step("dual.idle", 2'b00, 0, 0, 2'b00, 1'b0);

    // Address generation modes: LOAD needs J only, STORE needs J and K
    set_ent(10, LD, 1, 0, 1, 0, 4'd3);
    set_ent(11, ST, 1, 0, 1, 1, 0);
    step("agen", 2'b11, 10, 11, 2'b11, 1'b0);
    clr();

    // Load memory access gated by early stores; one per cycle
    set_ent(5, LD, 0, 1, 0, 0, 4'd2);
    step("ld.est2", 2'b00, 0, 0, 2'b00, 1'b0);
    set_ent(5, LD, 0, 1, 0, 0, 4'd0);
    set_ent(6, LD, 0, 1, 0, 0, 4'd0);
    step("ld.first", 2'b01, 5, 0, 2'b00, 1'b0);
    step("ld.second", 2'b01, 6, 0, 2'b00, 1'b0);
    clr();
    step("ld.idle", 2'b00, 0, 0, 2'b00, 1'b0);

    // Branch limit
    set_ent(0, BR, 1, 0, 1, 1, 0);
    set_ent(1, BR, 1, 0, 1, 1, 0);
    set_ent(2, ALU, 1, 0, 1, 1, 0);
    step("br.pair", 2'b11, 0, 2, 2'b00, 1'b0);
    step("br.next", 2'b01, 1, 0, 2'b00, 1'b0);
    clr();
    step("br.idle", 2'b00, 0, 0, 2'b00, 1'b0);

    // Stall holds slots; flush under stall clears them
    set_ent(4, ALU, 1, 0, 1, 1, 0);
    set_ent(8, ALU, 1, 0, 1, 1, 0);
    step("stl.issue", 2'b11, 4, 8, 2'b00, 1'b0);
    set_ent(0, ALU, 1, 0, 1, 1, 0);
    ex_stall = 1'b1;
    for (int c = 0; c < 3; c++) step("stl.hold", 2'b11, 4, 8, 2'b00, 1'b0);
    flush = 1'b1;
    step("stl.flush", 2'b00, 0, 0, 2'b00, 1'b0);
    flush = 1'b0; ex_stall = 1'b0;
    // Inflight mask was cleared by the flush, so 4 is selectable again
    step("stl.resume", 2'b11, 0, 4, 2'b00, 1'b0);
    clr();
    step("stl.idle", 2'b00, 0, 0, 2'b00, 1'b0);

    // Divider occupancy: second DIV issues 33 cycles after the first
    set_ent(1, DIV, 1, 0, 1, 1, 0);
    set_ent(2, DIV, 1, 0, 1, 1, 0);
    step("div.first", 2'b01, 1, 0, 2'b00, 1'b1);
    set_ent(1, DIV, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 32; k++)
      step($sformatf("div.wait%0d", k), 2'b00, 0, 0, 2'b00, (k < 32));
    step("div.second", 2'b01, 2, 0, 2'b00, 1'b1);
    clr();
    for (int c = 0; c < 3; c++) step("div.busy", 2'b00, 0, 0, 2'b00, 1'b1);
    flush = 1'b1;
    step("div.flush", 2'b00, 0, 0, 2'b00, 1'b1);
    flush = 1'b0;
    // Reset mid-divide clears the counter; reset beats a concurrent flush
    reset = 1'b0; flush = 1'b1;
    step("div.rst", 2'b00, 0, 0, 2'b00, 1'b0);
    reset = 1'b1; flush = 1'b0;
    set_ent(13, DIV, 1, 0, 1, 1, 0);
    step("div.after", 2'b01, 13, 0, 2'b00, 1'b1);
    clr();
    step("div.idle", 2'b00, 0, 0, 2'b00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
